// File: rtl/result_writer.sv
// Purpose : captures multiplier products and writes them to sequential result-RAM addresses, DEPTH words per run.
// Latency : 1 cycle from the clka edge that samples product_valid to ena/wea/addra/dina.
// Backpressure: none. Valids in IDLE are dropped. Valids after DEPTH writes set the sticky overflow flag.
//
// Ports:
//   clka, rst_n           clock (rising edge) and asynchronous active-low reset
//   start_stop            run enable; low returns to IDLE and clears the run state
//   product/product_valid multiplier result and its single-cycle qualifier
//   ena/wea/addra/dina    result-RAM write port (registered)
//   count/done/overflow   run status: words written, all DEPTH written, valid seen while done
//   checksum              XOR of the products written this run (only with RESULT_CHECKSUM_EN)
//
// Optional feature macro: RESULT_CHECKSUM_EN adds the checksum output.
module result_writer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic [DATA_W-1:0] product,
    input  logic              product_valid,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W:0]   count,
`ifdef RESULT_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done,
    output logic              overflow
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    // The write that brings the count to DEPTH is the last one of the run.
    logic last_write;
    assign last_write = (count_q == CNT_W'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        wr_d       = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
`ifdef RESULT_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        if (!start_stop) begin
            // Dropping start_stop wins over a coincident valid: no write is issued.
            state_d    = IDLE;
            ptr_d      = '0;
            count_d    = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The enabling cycle itself never writes; clear run state on the way in.
                    state_d    = RUN;
                    ptr_d      = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
`ifdef RESULT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
                RUN: begin
                    if (product_valid) begin
                        wr_d    = 1'b1;
                        addra_d = ptr_q;
                        dina_d  = product;
                        // Pointer wraps to 0 exactly when the run fills.
                        ptr_d   = ptr_q + ADDR_W'(1);
                        count_d = count_q + CNT_W'(1);
`ifdef RESULT_CHECKSUM_EN
                        csum_d  = csum_q ^ product;
`endif
                        if (last_write) begin
                            state_d = FULL;
                            done_d  = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (product_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_q       <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
`ifdef RESULT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            wr_q       <= wr_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
`ifdef RESULT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // ena and wea are driven from the same flop; the RAM is only touched to write.
    assign ena      = wr_q;
    assign wea      = wr_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign count    = count_q;
    assign done     = done_q;
    assign overflow = overflow_q;
`ifdef RESULT_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic              clka = 1'b0;
    logic              rst_n;
    logic              start_stop;
    logic [DATA_W-1:0] product;
    logic              product_valid;
    logic              ena, wea, done, overflow;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [ADDR_W:0]   count;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clka = ~clka;

    result_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .start_stop    (start_stop),
        .product       (product),
        .product_valid (product_valid),
        .ena           (ena),
        .wea           (wea),
        .addra         (addra),
        .dina          (dina),
        .count         (count),
`ifdef RESULT_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .done          (done),
        .overflow      (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Run-level view: is a run armed, how many words it has written, whether
    // an extra valid arrived after it filled, and the last write issued.
    bit          m_armed;
    int          m_written;
    bit          m_ovf;
    bit          m_wr;
    int unsigned m_addr;
    logic [31:0] m_data;
    logic [31:0] m_sum;

    always @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 0; m_written = 0; m_ovf = 0; m_wr = 0;
            m_addr = 0; m_data = 0; m_sum = 0;
        end else begin
            m_wr = 0;
            if (!start_stop) begin
                m_armed = 0; m_written = 0; m_ovf = 0; m_sum = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (m_written == DEPTH) begin
                if (product_valid) m_ovf = 1;
            end else if (product_valid) begin
                m_wr      = 1;
                m_addr    = m_written % DEPTH;
                m_data    = product;
                m_sum     = m_sum ^ product;
                m_written = m_written + 1;
            end
        end
    end

    // Log of writes observed on the RAM port, for the hand-computed checks.
    int unsigned log_a[$];
    logic [31:0] log_d[$];

    always @(negedge clka) begin
        if (rst_n === 1'b1) begin
            check("ena",      64'(ena),      64'(m_wr));
            check("wea",      64'(wea),      64'(m_wr));
            check("addra",    64'(addra),    64'(m_addr));
            check("dina",     64'(dina),     64'(m_data));
            check("count",    64'(count),    64'(m_written));
            check("done",     64'(done),     64'(m_written == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef RESULT_CHECKSUM_EN
            check("checksum", 64'(checksum), 64'(m_sum));
`endif
            if (wea === 1'b1) begin
                log_a.push_back(32'(addra));
                log_d.push_back(dina);
            end
        end
    end

    // Drive inputs for one cycle; returns 1 time unit after the sampling edge.
    task automatic step(input logic ss, input logic v, input logic [31:0] p);
        start_stop    = ss;
        product_valid = v;
        product       = p;
        @(posedge clka);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_stop = 1'b0; product_valid = 1'b0; product = '0;
        #12;
        check("rst_ena",   64'(ena),   64'd0);
        check("rst_wea",   64'(wea),   64'd0);
        check("rst_addra", 64'(addra), 64'd0);
        check("rst_dina",  64'(dina),  64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        @(posedge clka); #1;
        rst_n = 1'b1;
        step(0, 0, 0);

        // Burst of 8 back-to-back products 1..8.
        clear_log();
        step(1, 1, 32'h99);                  // arming cycle: valid ignored
        for (int i = 1; i <= 8; i++) step(1, 1, 32'(i));
        check("burst_count", 64'(count), 64'd8);
        check("burst_done",  64'(done),  64'd1);
        step(1, 0, 0);
        check("burst_nwr", 64'(log_a.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            check("burst_addr", 64'(log_a[i]), 64'(i));
            check("burst_data", 64'(log_d[i]), 64'(i + 1));
        end

        // Overflow after done.
        step(1, 1, 32'hFFFF_FFFF);
        check("ovf_wea", 64'(wea),      64'd0);
        check("ovf_set", 64'(overflow), 64'd1);
        step(1, 0, 0);
        step(1, 0, 0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_nwr",    64'(log_a.size()), 64'd8);
        step(0, 0, 0);
        check("ovf_clear", 64'(overflow), 64'd0);
        check("idle_cnt",  64'(count),    64'd0);

        // Gapped writes.
        clear_log();
        step(1, 0, 0);
        step(1, 1, 32'hDEAD_BEEF);
        step(1, 0, 0);
        check("gap_wea", 64'(wea), 64'd0);
        step(1, 1, 32'h1);
        step(1, 0, 0);
        check("gap_count", 64'(count), 64'd2);
        check("gap_done",  64'(done),  64'd0);
        check("gap_nwr",   64'(log_a.size()), 64'd2);
        if (log_a.size() == 2) begin
            check("gap_a0", 64'(log_a[0]), 64'd0);
            check("gap_d0", 64'(log_d[0]), 64'hDEAD_BEEF);
            check("gap_a1", 64'(log_a[1]), 64'd1);
            check("gap_d1", 64'(log_d[1]), 64'h1);
        end
        step(0, 0, 0);

        // Abort coincident with a valid after 3 writes, then restart.
        clear_log();
        step(1, 0, 0);
        step(1, 1, 32'h11);
        step(1, 1, 32'h22);
        step(1, 1, 32'h33);
        step(0, 1, 32'h44);
        check("abort_wea",   64'(wea),   64'd0);
        check("abort_count", 64'(count), 64'd0);
        check("abort_nwr",   64'(log_a.size()), 64'd3);
        clear_log();
        step(1, 0, 0);
        step(1, 1, 32'hA5);
        step(1, 0, 0);
        check("restart_nwr", 64'(log_a.size()), 64'd1);
        if (log_a.size() == 1) check("restart_a0", 64'(log_a[0]), 64'd0);
        step(0, 0, 0);

`ifdef RESULT_CHECKSUM_EN
        step(1, 0, 0);
        step(1, 1, 32'hF0F0_F0F0);
        step(1, 1, 32'h0F0F_0F0F);
        step(1, 0, 0);
        check("csum_lit", 64'(checksum), 64'hFFFF_FFFF);
        step(0, 0, 0);
        check("csum_clr", 64'(checksum), 64'd0);
`endif

        // Asynchronous reset while a write is on the port.
        step(1, 0, 0);
        step(1, 1, 32'h5A5A_5A5A);
        check("pre_rst_wea", 64'(wea), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_wea",   64'(wea),   64'd0);
        check("arst_ena",   64'(ena),   64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_done",  64'(done),  64'd0);
        check("arst_ovf",   64'(overflow), 64'd0);
        @(posedge clka); #1;
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
